// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder slice plus a registered carry,
// processing LSB first, WIDTH clocks per operation.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic w_accept;
  logic w_step;
  logic w_last;
  logic w_s;
  logic w_c;

  // Single full-adder slice on the current LSBs.
  assign w_s = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_c = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);

  assign w_last = (r_count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Subtraction is a + ~b + 1, so the inversion and forced carry are applied at load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= i_a;
      r_opb   <= i_sub ? ~i_b : i_b;
      r_carry <= i_sub ? 1'b1 : i_cin;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_step) begin
      r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
      r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_c;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        // r_carry here is the carry into the MSB.
        r_cout <= w_c;
        r_ovf  <= r_carry ^ w_c;
      end
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
// Randomised and directed check of serial_adder_n against an arithmetic model.
module tb_serial_adder_n;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_sub = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         i_cin = 1'b0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder_n #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_start(i_start),
    .i_sub  (i_sub),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_cin  (i_cin),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_sum  (o_sum),
    .o_cout (o_cout),
    .o_ovf  (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    int unsigned mask = (1 << W) - 1;
    int unsigned hmask = (1 << (W - 1)) - 1;
    int unsigned bb = sub ? ((~int'(b)) & mask) : int'(b);
    int unsigned c0 = sub ? 1 : int'(cin);
    int unsigned full = int'(a) + bb + c0;
    int unsigned low = (int'(a) & hmask) + (bb & hmask) + c0;
    logic cout = full[W];
    logic cmsb = low[W-1];
    return {cout ^ cmsb, cout, full[W-1:0]};
  endfunction

  // Caller must be at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    i_a = a; i_b = b; i_cin = cin; i_sub = sub; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_a = W'($urandom); i_b = W'($urandom);
    i_cin = 1'($urandom); i_sub = 1'($urandom);
  endtask

  task automatic wait_done(output int busy_cnt, output bit seen);
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (o_busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sub);
    logic [W+1:0] e = model(a, b, cin, sub);
    chk({tag, ".sum"},  32'(o_sum),  32'(e[W-1:0]));
    chk({tag, ".cout"}, 32'(o_cout), 32'(e[W]));
    chk({tag, ".ovf"},  32'(o_ovf),  32'(e[W+1]));
    $display("[TB] %s a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d",
             tag, a, b, cin, sub, o_sum, o_cout, o_ovf);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int  bc;
    bit  seen;
    logic [W+1:0] e = model(a, b, cin, sub);
    start_op(a, b, cin, sub);
    wait_done(bc, seen);
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".busy_cycles"}, 32'(bc), 32'(W));
    check_result(tag, a, b, cin, sub);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(o_busy), 32'd0);
    chk({tag, ".hold_sum"}, 32'(o_sum), 32'(e[W-1:0]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, 32'(o_busy), 32'd0);
    chk({tag, ".done"}, 32'(o_done), 32'd0);
    chk({tag, ".sum"},  32'(o_sum),  32'd0);
    chk({tag, ".cout"}, 32'(o_cout), 32'd0);
    chk({tag, ".ovf"},  32'(o_ovf),  32'd0);
  endtask

  initial begin
    int  bc;
    bit  seen;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    // Power-up reset, checked before any clock edge.
    #2;
    check_zero("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op("add_35_1a", 8'h35, 8'h1A, 1'b0, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);

    // Asynchronous reset while idle with a non-zero result held.
    #2 rst = 1'b1;
    #1 check_zero("rst_idle");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // start pulsed during RUN must be ignored.
    start_op(8'h5A, 8'h33, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    i_a = 8'hC3; i_b = 8'h99; i_cin = 1'b0; i_sub = 1'b1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(bc, seen);
    chk("run_start.done_seen", 32'(seen), 32'd1);
    check_result("run_start", 8'h5A, 8'h33, 1'b1, 1'b0);

    // Back-to-back: start while in DONE.
    start_op(8'h9C, 8'h47, 1'b0, 1'b1);
    chk("b2b.done_drop", 32'(o_done), 32'd0);
    chk("b2b.busy", 32'(o_busy), 32'd1);
    wait_done(bc, seen);
    chk("b2b.done_seen", 32'(seen), 32'd1);
    chk("b2b.busy_cycles", 32'(bc), 32'(W));
    check_result("b2b", 8'h9C, 8'h47, 1'b0, 1'b1);
    @(negedge clk);

    // Reset during RUN cycle 4 aborts with no done pulse.
    start_op(8'hAB, 8'hCD, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("rst_run");
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_done || o_busy) seen = 1'b1;
    end
    chk("rst_run.no_done", 32'(seen), 32'd0);

    // Full-adder truth table on bit 0.
    for (int v = 0; v < 8; v++) begin
      logic a0 = 1'(v >> 2);
      logic b0 = 1'(v >> 1);
      logic c0 = 1'(v);
      start_op({7'b0, a0}, {7'b0, b0}, c0, 1'b0);
      wait_done(bc, seen);
      chk($sformatf("fa%0d.done_seen", v), 32'(seen), 32'd1);
      chk($sformatf("fa%0d.s", v), 32'(o_sum[0]), 32'(a0 ^ b0 ^ c0));
      chk($sformatf("fa%0d.c", v), 32'(o_sum[1]), 32'((a0 & b0) | (a0 & c0) | (b0 & c0)));
      $display("[TB] fa a0=%0d b0=%0d cin=%0d -> sum[1:0]=%02b", a0, b0, c0, o_sum[1:0]);
      @(negedge clk);
    end

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      do_op($sformatf("rnd%0d", n), ra, rb, rc, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
